// File: rtl/data_mem_ctrl_pkg.sv
// Shared CPU definitions: ALU ops, opcodes, and the data-memory controller's
// state encoding and byte-lane constants.
package data_mem_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } aluOp_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_LB    = 6'h20,
    OP_LW    = 6'h23,
    OP_SB    = 6'h28,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } memState_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam int         LANE_W  = 2;

  // Little-endian: byte lane i carries address offset i.
  function automatic logic [3:0] laneOneHot(input logic [LANE_W-1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_byte_lane.sv
// Combinational byte-lane steering: byte enables, store-data replication and
// load byte select with sign extension.
module byte_lane_unit
  import data_mem_ctrl_pkg::*;
(
  input  logic              byteOp,
  input  logic [LANE_W-1:0] lane,
  input  logic [31:0]       storeData,
  input  logic [31:0]       loadWord,
  output logic [3:0]        be,
  output logic [31:0]       storeLanes,
  output logic [31:0]       loadResult
);

  logic [7:0] loadByte;

  always_comb begin
    loadByte   = loadWord[{lane, 3'b000} +: 8];
    be         = byteOp ? laneOneHot(lane) : BE_WORD;
    storeLanes = byteOp ? {4{storeData[7:0]}} : storeData;
    loadResult = byteOp ? {{24{loadByte[7]}}, loadByte} : loadWord;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: turns decoder MemRead/MemWrite into single
// request/ack transactions on a backing RAM, holding the pipeline meanwhile.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              byte_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              stall,
  output logic              align_err,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  output memState_e         dbgState
);

  // Handshake: ram_req rises when an access is accepted and is held, with
  // ram_addr/ram_we/ram_be/ram_wdata frozen, until the cycle ram_ack is seen.
  // ram_ack in any other state has no effect.

  memState_e         state;
  logic              holdOff;
  logic              latByte;
  logic [LANE_W-1:0] latLane;

  logic              reqAny;
  logic              wordMis;
  logic              accept;
  logic              alignHit;
  logic              unitByte;
  logic [LANE_W-1:0] unitLane;
  logic [3:0]        unitBe;
  logic [31:0]       unitStore;
  logic [31:0]       unitLoad;

  always_comb begin
    // holdOff masks the cycle after DONE so a request still held by the
    // pipeline for the finished instruction is not accepted again.
    reqAny   = (mem_read | mem_write) & ~holdOff & (state == MEM_IDLE);
    wordMis  = ~byte_op & (addr[1:0] != 2'b00);
    accept   = reqAny & ~wordMis;
    alignHit = reqAny & wordMis & ~(mem_read & mem_write);
    stall    = rst_b & (accept | (state == MEM_WAIT));
    unitByte = (state == MEM_IDLE) ? byte_op   : latByte;
    unitLane = (state == MEM_IDLE) ? addr[1:0] : latLane;
  end

  byte_lane_unit uLanes (
    .byteOp     (unitByte),
    .lane       (unitLane),
    .storeData  (wdata),
    .loadWord   (ram_rdata),
    .be         (unitBe),
    .storeLanes (unitStore),
    .loadResult (unitLoad)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= MEM_IDLE;
      holdOff   <= 1'b0;
      done      <= 1'b0;
      align_err <= 1'b0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_be    <= BE_NONE;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata     <= '0;
      latByte   <= 1'b0;
      latLane   <= '0;
    end else begin
      done      <= 1'b0;
      align_err <= 1'b0;
      holdOff   <= (state == MEM_DONE);
      case (state)
        MEM_IDLE: begin
          align_err <= alignHit;
          if (accept) begin
            state     <= MEM_WAIT;
            ram_req   <= 1'b1;
            ram_we    <= mem_write;
            ram_addr  <= addr[ADDR_W-1:2];
            ram_be    <= unitBe;
            ram_wdata <= unitStore;
            latByte   <= byte_op;
            latLane   <= addr[1:0];
          end
        end
        MEM_WAIT: begin
          if (ram_ack) begin
            state   <= MEM_DONE;
            ram_req <= 1'b0;
            done    <= 1'b1;
            if (!ram_we) rdata <= unitLoad;
          end
        end
        MEM_DONE: state <= MEM_IDLE;
        default:  state <= MEM_IDLE;
      endcase
    end
  end

  assign dbgState = state;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus random
// loads/stores scored against a byte-addressed reference memory.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, byte_op = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, ram_wdata;
  logic        done, stall, align_err, ram_req, ram_we;
  logic [29:0] ram_addr;
  logic [3:0]  ram_be;
  logic        ram_ack = 1'b0;
  logic [31:0] ram_rdata = '0;
  memState_e   dbgState;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_b(rst_b), .mem_read(mem_read), .mem_write(mem_write),
    .byte_op(byte_op), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
    .stall(stall), .align_err(align_err), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata), .dbgState(dbgState)
  );

  // ---------------- scoreboard state ----------------
  int          nVec = 0, nErr = 0;
  logic [31:0] exp_q[$];
  logic [66:0] expTxn_q[$];
  logic [66:0] txnMask_q[$];
  int          expAlign = 0;
  int          doneCnt = 0, txnCnt = 0, stallCnt = 0, reqCycles = 0;
  bit          sawDone = 0;
  bit          prevReq = 0;
  bit          respEnable = 1;
  int          fixedLat = -1;
  logic [7:0]  refMem [int];
  logic [31:0] ramMem [int];
  logic [31:0] lastRd = '0;

  function automatic logic [31:0] initWord(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [7:0] refByte(input int a);
    logic [31:0] w;
    if (refMem.exists(a)) return refMem[a];
    w = initWord(a / 4);
    return w[8*(a%4) +: 8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setWord(input int a, input logic [31:0] v);
    int wb;
    wb = a - (a % 4);
    ramMem[wb/4] = v;
    for (int i = 0; i < 4; i++) refMem[wb+i] = v[8*i +: 8];
  endtask

  // Reference model: a load returns the addressed bytes (sign-extended for LB).
  task automatic pushRead(input logic [31:0] a, input bit bo);
    int          ia, wb;
    logic [31:0] word, res;
    logic [7:0]  b;
    logic [3:0]  hot;
    ia = int'(a);
    wb = ia - (ia % 4);
    for (int i = 0; i < 4; i++) word[8*i +: 8] = refByte(wb + i);
    b   = refByte(ia);
    res = bo ? {{24{b[7]}}, b} : word;
    hot = 4'b0001 << a[1:0];
    lastRd = res;
    exp_q.push_back(res);
    expTxn_q.push_back({1'b0, a[31:2], bo ? hot : 4'hF, 32'h0});
    txnMask_q.push_back({1'b1, {30{1'b1}}, bo ? 4'h0 : 4'hF, 32'h0});
  endtask

  // A store updates only the addressed bytes; rdata must keep its last load.
  task automatic pushWrite(input logic [31:0] a, input bit bo, input logic [31:0] wd);
    int          ia, wb;
    logic [3:0]  be;
    logic [31:0] wl;
    ia = int'(a);
    wb = ia - (ia % 4);
    be = bo ? (4'b0001 << a[1:0]) : 4'hF;
    wl = bo ? {4{wd[7:0]}} : wd;
    for (int i = 0; i < 4; i++) if (be[i]) refMem[wb+i] = wl[8*i +: 8];
    exp_q.push_back(lastRd);
    expTxn_q.push_back({1'b1, a[31:2], be, wl});
    txnMask_q.push_back({67{1'b1}});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [66:0] e, m, act;
    if (stall) stallCnt++;
    if (ram_req) reqCycles++;
    if (ram_req && !prevReq) txnCnt++;
    prevReq = ram_req;
    if (done) begin
      doneCnt++;
      sawDone = 1;
      if (exp_q.size() == 0) begin
        nVec++; nErr++;
        $display("FAIL unexpected_done: got done with rdata %h, required no done", rdata);
      end else begin
        check("rdata", rdata, exp_q.pop_front());
      end
      check("stall_in_done", 32'(stall), 32'd0);
    end
    if (ram_req && ram_ack) begin
      nVec++;
      act = {ram_we, ram_addr, ram_be, ram_wdata};
      if (expTxn_q.size() == 0) begin
        nErr++;
        $display("FAIL unexpected_txn: got %h, required no RAM transaction", act);
      end else begin
        e = expTxn_q.pop_front();
        m = txnMask_q.pop_front();
        if ((act & m) !== (e & m)) begin
          nErr++;
          $display("FAIL ram_txn: got we/addr/be/wdata %h required %h (mask %h)", act, e, m);
        end
      end
    end
    if (align_err) begin
      nVec++;
      if (expAlign == 0) begin
        nErr++;
        $display("FAIL unexpected_align_err: got 1 required 0");
      end else expAlign--;
    end
  end

  // ---------------- RAM responder ----------------
  initial begin
    bit busy = 0;
    int cnt = 0;
    logic [31:0] w;
    forever begin
      @(posedge clk); #2;
      if (!respEnable) begin busy = 0; continue; end
      ram_ack = 1'b0;
      if (!ram_req) busy = 0;
      else begin
        if (!busy) begin
          busy = 1;
          cnt = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
        end
        if (cnt == 0) begin
          w = ramMem.exists(int'(ram_addr)) ? ramMem[int'(ram_addr)] : initWord(int'(ram_addr));
          if (ram_we) begin
            for (int i = 0; i < 4; i++) if (ram_be[i]) w[8*i +: 8] = ram_wdata[8*i +: 8];
            ramMem[int'(ram_addr)] = w;
            ram_rdata = $urandom;
          end else ram_rdata = w;
          ram_ack = 1'b1;
          busy = 0;
        end else cnt--;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic doAccess(input bit rd, input bit wr, input bit bo,
                          input logic [31:0] a, input logic [31:0] wd);
    bit mis;
    int k;
    mis = !bo && (a[1:0] != 2'b00);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; byte_op = bo; addr = a; wdata = wd;
    sawDone = 0;
    if (mis) begin
      if (!(rd && wr)) expAlign++;
      @(posedge clk); #1;
      mem_read = 0; mem_write = 0;
      @(posedge clk); #1;
      return;
    end
    if (wr) pushWrite(a, bo, wd);
    else pushRead(a, bo);
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (sawDone) break;
    end
    if (k == 100) begin
      nVec++; nErr++;
      $display("FAIL done_timeout: got no done in 100 cycles for addr %h, required done", a);
    end
    mem_read = 0; mem_write = 0;
  endtask

  task automatic waitDones(input int target, input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (doneCnt >= target) break;
    end
    if (k == 100) begin
      nVec++; nErr++;
      $display("FAIL %s: got done count %0d, required %0d", name, doneCnt, target);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, t0;
    bit rd, wr, bo;
    int kind;
    logic [31:0] a;

    // Reset with a request present: stall must stay low.
    mem_read = 1; addr = 32'h10;
    repeat (2) @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      check("stall_in_reset", 32'(stall), 32'd0);
    end
    check("rst_done", 32'(done), 32'd0);
    check("rst_ram_req", 32'(ram_req), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_align_err", 32'(align_err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ram_be", 32'(ram_be), 32'd0);
    check("rst_state", 32'(dbgState), 32'(MEM_IDLE));
    mem_read = 0;
    @(posedge clk); #1;
    rst_b = 1;

    // LW with ack on the third WAIT cycle.
    setWord(32'h10, 32'hDEADBEEF);
    fixedLat = 2;
    @(posedge clk); #1;
    stallCnt = 0;
    doAccess(1, 0, 0, 32'h10, 32'h0);
    check("lw_stall_cycles", 32'(stallCnt), 32'd4);
    check("lw_rdata", rdata, 32'hDEADBEEF);

    // SB to lane 3, then LB negative and positive bytes.
    fixedLat = 1;
    doAccess(0, 1, 1, 32'h13, 32'h000000A5);
    check("sb_keeps_rdata", rdata, 32'hDEADBEEF);
    fixedLat = 0;
    setWord(32'h20, 32'h12805634);
    doAccess(1, 0, 1, 32'h22, 32'h0);
    check("lb_sext_neg", rdata, 32'hFFFFFF80);
    doAccess(1, 0, 1, 32'h21, 32'h0);
    check("lb_sext_pos", rdata, 32'h00000056);

    // Misaligned LW.
    @(posedge clk); #1;
    reqCycles = 0;
    mem_read = 1; byte_op = 0; addr = 32'h06;
    expAlign++;
    @(negedge clk);
    check("misaligned_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem_read = 0;
    @(negedge clk);
    check("align_pulse", 32'(align_err), 32'd1);
    @(negedge clk);
    check("align_one_cycle", 32'(align_err), 32'd0);
    check("misaligned_no_req", 32'(reqCycles), 32'd0);

    // Reset during WAIT, then a late ack.
    respEnable = 0;
    @(posedge clk); #1;
    ram_ack = 0;
    mem_read = 1; byte_op = 0; addr = 32'h30;
    @(posedge clk); #1;
    mem_read = 0;
    @(negedge clk);
    check("wait_req", 32'(ram_req), 32'd1);
    @(posedge clk); #1;
    rst_b = 0;
    @(posedge clk); #1;
    rst_b = 1;
    @(negedge clk);
    check("abort_req", 32'(ram_req), 32'd0);
    check("abort_state", 32'(dbgState), 32'(MEM_IDLE));
    d0 = doneCnt;
    @(posedge clk); #1;
    ram_ack = 1; ram_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    ram_ack = 0;
    repeat (3) @(negedge clk);
    check("late_ack_no_done", 32'(doneCnt - d0), 32'd0);
    check("late_ack_state", 32'(dbgState), 32'(MEM_IDLE));
    check("late_ack_rdata", rdata, 32'd0);
    lastRd = 32'd0;
    respEnable = 1;

    // mem_read held across two back-to-back LWs.
    fixedLat = 0;
    setWord(32'h40, 32'h0BADF00D);
    setWord(32'h44, 32'hCAFE1234);
    pushRead(32'h40, 0);
    pushRead(32'h44, 0);
    @(posedge clk); #1;
    d0 = doneCnt; t0 = txnCnt;
    mem_read = 1; byte_op = 0; addr = 32'h40;
    waitDones(d0 + 1, "held_first_done");
    addr = 32'h44;
    waitDones(d0 + 2, "held_second_done");
    mem_read = 0;
    repeat (4) @(posedge clk);
    check("held_txn_count", 32'(txnCnt - t0), 32'd2);
    check("held_done_count", 32'(doneCnt - d0), 32'd2);

    // Random mix of loads, stores and misaligned word reads.
    fixedLat = -1;
    repeat (250) begin
      kind = int'($urandom_range(0, 9));
      bo   = $urandom_range(0, 1) == 1;
      a    = 32'($urandom_range(0, 127));
      rd   = (kind <= 3) || (kind >= 8);
      wr   = (kind >= 4) && (kind <= 8);
      if (kind == 9) begin
        bo = 0;
        if (a[1:0] == 2'b00) a[0] = 1'b1;
      end else if (!bo) a[1:0] = 2'b00;
      doAccess(rd, wr, bo, a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    check("pending_done", 32'(exp_q.size()), 32'd0);
    check("pending_txn", 32'(expTxn_q.size()), 32'd0);
    check("pending_align", 32'(expAlign), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by 1ms, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of addr.
REQ-002 Parameter DATA_W, default 32, data word width; fixed at 32, other values unsupported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_b  input  1  reset, synchronous and active-low.
REQ-005 mem_read  input  1  load request from decoder MemRead.
REQ-006 mem_write  input  1  store request from decoder MemWrite.
REQ-007 byte_op  input  1  1 = LB/SB, 0 = LW/SW.
REQ-008 addr  input  ADDR_W  byte address (ALU result).
REQ-009 wdata  input  32  store data (rt).
REQ-010 rdata  output  32  load result, valid while done=1.
REQ-011 done  output  1  one-cycle pulse marking access completion.
REQ-012 stall  output  1  pipeline hold while an access is in flight.
REQ-013 align_err  output  1  one-cycle pulse for a misaligned word access.
REQ-014 ram_req  output  1  backing-RAM request, level-held until ack.
REQ-015 ram_we  output  1  1 = write cycle.
REQ-016 ram_addr  output  ADDR_W-2  word address = addr[ADDR_W-1:2].
REQ-017 ram_be  output  4  byte enables, bit i = byte lane i.
REQ-018 ram_wdata  output  32  write data.
REQ-019 ram_ack  input  1  one-cycle completion from RAM, arbitrary latency >= 1 cycle.
REQ-020 ram_rdata  input  32  read word, valid in the ack cycle.

Function
REQ-021 FSM states IDLE, WAIT, DONE; encoding is free.
REQ-022 IDLE with mem_read|mem_write and access aligned: latch addr, wdata, byte_op and direction; go to WAIT.
REQ-023 stall = 1 combinationally in IDLE when a valid request is present, and stall = 1 throughout WAIT.
REQ-024 stall = 0 in DONE and when idle with no request.
REQ-025 WAIT: ram_req = 1; ram_addr, ram_we, ram_be and ram_wdata are driven from latched values and stay stable until ack.
REQ-026 WAIT with ram_ack = 1: capture the result, go to DONE.
REQ-027 DONE lasts exactly one cycle: done = 1, ram_req = 0, then return to IDLE.
REQ-028 Re-acceptance is gated one cycle after DONE, so a held request is not serviced twice.
REQ-029 Minimum latency is request cycle to done = 2 cycles (ack on the first WAIT cycle).
REQ-030 Little-endian byte lanes: lane = addr[1:0].
REQ-031 Word access: ram_be = 4'b1111; rdata = ram_rdata.
REQ-032 SB: ram_be = one-hot(lane); ram_wdata = wdata[7:0] replicated to all four lanes.
REQ-033 LB: rdata = sign-extend(ram_rdata[8*lane+7 : 8*lane]).
REQ-034 Word access with addr[1:0] != 0: no RAM request, align_err = 1 for that cycle, stall = 0, stay in IDLE.
REQ-035 mem_read and mem_write both 1: treated as a write; align_err is not raised.
REQ-036 ram_ack outside WAIT is ignored.
REQ-037 rdata holds its last captured value outside DONE; for writes, rdata is unchanged.

Reset
REQ-038 rst_b = 0 at a clock edge: state to IDLE; done, align_err, ram_req and ram_we to 0; rdata to 0; ram_be to 0.
REQ-039 Reset during WAIT abandons the access: ram_req = 0 from the next cycle, and a late ack is ignored.
REQ-040 stall = 0 while rst_b = 0.

Structure
REQ-041 The FSM state enum and the lane/byte-enable constants live in the shared CPU package alongside the ALU op and opcode definitions.
REQ-042 One sub-module, byte_lane_unit (combinational): generates be, replicates store data and selects/sign-extends load bytes.

Verification
REQ-043 LW at addr 0x10, ack after 3 cycles, ram_rdata 0xDEADBEEF -> stall high for 4 cycles, done pulse, rdata = 0xDEADBEEF, ram_be = 4'hF.
REQ-044 SB at addr 0x13 with wdata 0x000000A5 -> ram_be = 4'b1000, ram_wdata = 0xA5A5A5A5, ram_we = 1, done after ack.
REQ-045 LB at addr 0x22, ram_rdata 0x12805634 -> rdata = 0xFFFFFF80; LB at 0x21 -> rdata = 0x00000056.
REQ-046 LW at addr 0x06 -> align_err pulses for 1 cycle, ram_req never asserted, stall = 0.
REQ-047 Reset asserted in WAIT, then ack arrives 2 cycles later -> ram_req = 0 after the edge, no done pulse, state IDLE.
REQ-048 mem_read held high across two back-to-back LWs with immediate ack -> exactly two ram_req transactions and two done pulses, no duplicate access.
